// File: rtl/afu_mgr_pkg.sv
// Shared AFU-manager definitions: port-id sizing, mdata field layout and
// pack/unpack helpers for the {pad, port id, tag} mdata encoding.
package afu_mgr_pkg;

  // Helpers work on a fixed wide container; callers cast to their real width.
  localparam int MDATA_HELPER_W = 64;

  // The user tag always occupies the low end of mdata.
  localparam int TAG_LSB = 0;

  // Bits needed to name one of num_ports ports (at least one bit).
  function automatic int port_id_width(input int num_ports);
    return (num_ports <= 2) ? 1 : $clog2(num_ports);
  endfunction

  // The port id sits directly above the tag.
  function automatic int port_id_lsb(input int tag_width);
    return TAG_LSB + tag_width;
  endfunction

  // Build {zero pad, port id, tag}; fields are masked to their widths.
  function automatic logic [MDATA_HELPER_W-1:0] pack_mdata(
    input int          tag_width,
    input int          id_width,
    input logic [31:0] port_id,
    input logic [31:0] tag
  );
    logic [MDATA_HELPER_W-1:0] id_mask;
    logic [MDATA_HELPER_W-1:0] tag_mask;
    id_mask  = (MDATA_HELPER_W'(1) << id_width) - MDATA_HELPER_W'(1);
    tag_mask = (MDATA_HELPER_W'(1) << tag_width) - MDATA_HELPER_W'(1);
    return ((MDATA_HELPER_W'(port_id) & id_mask) << port_id_lsb(tag_width)) |
           ((MDATA_HELPER_W'(tag) & tag_mask) << TAG_LSB);
  endfunction

  // Extract the port-id field of an mdata word.
  function automatic logic [31:0] unpack_port_id(
    input int                        tag_width,
    input int                        id_width,
    input logic [MDATA_HELPER_W-1:0] mdata
  );
    logic [MDATA_HELPER_W-1:0] id_mask;
    id_mask = (MDATA_HELPER_W'(1) << id_width) - MDATA_HELPER_W'(1);
    return 32'((mdata >> port_id_lsb(tag_width)) & id_mask);
  endfunction

  // Extract the user-tag field of an mdata word.
  function automatic logic [31:0] unpack_tag(
    input int                        tag_width,
    input logic [MDATA_HELPER_W-1:0] mdata
  );
    logic [MDATA_HELPER_W-1:0] tag_mask;
    tag_mask = (MDATA_HELPER_W'(1) << tag_width) - MDATA_HELPER_W'(1);
    return 32'((mdata >> TAG_LSB) & tag_mask);
  endfunction

endpackage

// File: rtl/rd_req_arbiter_if.sv
// Bundle of the read-port, host request and host response signals around the
// read request arbiter. master = ports + host side, slave = arbiter.
interface rd_req_arbiter_if #(
  parameter int NUM_PORTS   = 4,
  parameter int ADDR_WIDTH  = 48,
  parameter int MDATA_WIDTH = 16,
  parameter int TAG_WIDTH   = 12,
  parameter int DATA_WIDTH  = 512
);
  logic [NUM_PORTS-1:0]            port_en;
  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS*TAG_WIDTH-1:0]  req_tag;
  logic [NUM_PORTS-1:0]            req_ready;
  logic                            out_rd_available;
  logic                            out_rd_en;
  logic [ADDR_WIDTH-1:0]           out_rd_addr;
  logic [MDATA_WIDTH-1:0]          out_rd_mdata;
  logic                            resp_valid;
  logic [MDATA_WIDTH-1:0]          resp_mdata;
  logic [DATA_WIDTH-1:0]           resp_data;
  logic [NUM_PORTS-1:0]            port_resp_valid;
  logic [TAG_WIDTH-1:0]            port_resp_tag;
  logic [DATA_WIDTH-1:0]           port_resp_data;
  logic [NUM_PORTS*16-1:0]         outstanding;
  logic                            idle;
  logic                            err_bad_id;
  logic                            err_underflow;

  modport master (
    output port_en, req_valid, req_addr, req_tag, out_rd_available,
           resp_valid, resp_mdata, resp_data,
    input  req_ready, out_rd_en, out_rd_addr, out_rd_mdata,
           port_resp_valid, port_resp_tag, port_resp_data,
           outstanding, idle, err_bad_id, err_underflow
  );

  modport slave (
    input  port_en, req_valid, req_addr, req_tag, out_rd_available,
           resp_valid, resp_mdata, resp_data,
    output req_ready, out_rd_en, out_rd_addr, out_rd_mdata,
           port_resp_valid, port_resp_tag, port_resp_data,
           outstanding, idle, err_bad_id, err_underflow
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves just past the winner on every grant.
module rr_arbiter
  import afu_mgr_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  localparam int IDX_W    = port_id_width(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] i_req,
  output logic [NUM_PORTS-1:0] o_grant,
  output logic [IDX_W-1:0]     o_grant_idx,
  output logic                 o_grant_valid
);

  logic [IDX_W-1:0]     r_ptr;
  logic [NUM_PORTS-1:0] w_grant;
  logic [IDX_W-1:0]     w_idx;
  logic [IDX_W-1:0]     w_cand;
  logic                 w_found;

  // Scan from the pointer, wrapping modulo NUM_PORTS; first requester wins.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_cand = IDX_W'((int'(r_ptr) + k) % NUM_PORTS);
      if (!w_found && i_req[w_cand]) begin
        w_grant[w_cand] = 1'b1;
        w_idx           = w_cand;
        w_found         = 1'b1;
      end
    end
  end

  // Advance the pointer past the winner; hold it when nobody is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (w_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : w_idx + IDX_W'(1);
    end
  end

  assign o_grant       = w_grant;
  assign o_grant_idx   = w_idx;
  assign o_grant_valid = w_found;

endmodule

// File: rtl/rd_req_arbiter.sv
// Shares the host read request channel among NUM_PORTS read ports: picks one
// eligible port per cycle, tags mdata with the port id, tracks per-port
// in-flight reads and steers read responses back to their port.
module rd_req_arbiter
  import afu_mgr_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int ADDR_WIDTH      = 48,
  parameter int MDATA_WIDTH     = 16,
  parameter int TAG_WIDTH       = 12,
  parameter int MAX_OUTSTANDING = 64,
  parameter int DATA_WIDTH      = 512
) (
  input logic            clk,
  input logic            reset,
  rd_req_arbiter_if.slave bus
);

  localparam int PID_W = port_id_width(NUM_PORTS);
  localparam int CNT_W = 16;

  // Refuse configurations whose mdata cannot hold {port id, tag}.
  if (TAG_WIDTH + PID_W > MDATA_WIDTH) begin : g_bad_mdata_cfg
    $error("rd_req_arbiter: TAG_WIDTH + port id width exceeds MDATA_WIDTH");
  end
  if (NUM_PORTS < 2 || NUM_PORTS > 16) begin : g_bad_ports_cfg
    $error("rd_req_arbiter: NUM_PORTS must be within 2..16");
  end

  logic [NUM_PORTS-1:0]   w_elig;
  logic [NUM_PORTS-1:0]   w_arb_req;
  logic [NUM_PORTS-1:0]   w_grant;
  logic [PID_W-1:0]       w_grant_idx;
  logic                   w_grant_valid;
  logic [ADDR_WIDTH-1:0]  w_sel_addr;
  logic [TAG_WIDTH-1:0]   w_sel_tag;
  logic [MDATA_WIDTH-1:0] w_req_mdata;
  logic [31:0]            w_resp_id;
  logic [TAG_WIDTH-1:0]   w_resp_tag;
  logic                   w_resp_bad;
  logic [NUM_PORTS-1:0]   w_resp_hit;
  logic [NUM_PORTS-1:0]   w_underflow;
  logic [NUM_PORTS-1:0]   w_cnt_zero;

  logic                   r_rd_en;
  logic [ADDR_WIDTH-1:0]  r_rd_addr;
  logic [MDATA_WIDTH-1:0] r_rd_mdata;
  logic [NUM_PORTS-1:0]   r_resp_valid;
  logic [TAG_WIDTH-1:0]   r_resp_tag;
  logic [DATA_WIDTH-1:0]  r_resp_data;
  logic                   r_err_bad_id;
  logic                   r_err_underflow;

  // Nothing is granted while the host channel is almost full.
  assign w_arb_req = w_elig & {NUM_PORTS{bus.out_rd_available}};

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr_arbiter (
    .clk           (clk),
    .reset         (reset),
    .i_req         (w_arb_req),
    .o_grant       (w_grant),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  assign bus.req_ready = w_grant;

  // One-hot mux of the winning port's address and tag.
  always_comb begin
    w_sel_addr = '0;
    w_sel_tag  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_grant[p]) begin
        w_sel_addr = bus.req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_tag  = bus.req_tag[p*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  assign w_req_mdata = MDATA_WIDTH'(pack_mdata(TAG_WIDTH, PID_W, 32'(w_grant_idx), 32'(w_sel_tag)));

  // Register the granted request toward the host for exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_mdata <= '0;
    end else begin
      r_rd_en <= w_grant_valid;
      if (w_grant_valid) begin
        r_rd_addr  <= w_sel_addr;
        r_rd_mdata <= w_req_mdata;
      end
    end
  end

  // Decode the response id; ids beyond the last port are foreign and dropped.
  assign w_resp_id  = unpack_port_id(TAG_WIDTH, PID_W, MDATA_HELPER_W'(bus.resp_mdata));
  assign w_resp_tag = TAG_WIDTH'(unpack_tag(TAG_WIDTH, MDATA_HELPER_W'(bus.resp_mdata)));
  assign w_resp_bad = bus.resp_valid & (w_resp_id >= 32'(NUM_PORTS));

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic [CNT_W-1:0] r_cnt;

    assign w_resp_hit[gi]  = bus.resp_valid & (w_resp_id == 32'(gi));
    assign w_elig[gi]      = bus.req_valid[gi] & bus.port_en[gi] &
                             (r_cnt < CNT_W'(MAX_OUTSTANDING));
    assign w_cnt_zero[gi]  = (r_cnt == '0);
    // A response with nothing in flight and no same-cycle grant is an underflow.
    assign w_underflow[gi] = w_resp_hit[gi] & ~w_grant[gi] & w_cnt_zero[gi];
    assign bus.outstanding[gi*CNT_W +: CNT_W] = r_cnt;

    // In-flight count: +1 per grant, -1 per response, saturating at zero.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt <= '0;
      end else if (w_grant[gi] && !w_resp_hit[gi]) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_resp_hit[gi] && !w_grant[gi] && !w_cnt_zero[gi]) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // Steer each good response to its port with registered tag and data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_valid <= '0;
      r_resp_tag   <= '0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= w_resp_hit;
      if (bus.resp_valid && !w_resp_bad) begin
        r_resp_tag  <= w_resp_tag;
        r_resp_data <= bus.resp_data;
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_bad_id    <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      r_err_bad_id    <= r_err_bad_id | w_resp_bad;
      r_err_underflow <= r_err_underflow | (|w_underflow);
    end
  end

  assign bus.out_rd_en       = r_rd_en;
  assign bus.out_rd_addr     = r_rd_addr;
  assign bus.out_rd_mdata    = r_rd_mdata;
  assign bus.port_resp_valid = r_resp_valid;
  assign bus.port_resp_tag   = r_resp_tag;
  assign bus.port_resp_data  = r_resp_data;
  assign bus.idle            = (&w_cnt_zero) & ~r_rd_en;
  assign bus.err_bad_id      = r_err_bad_id;
  assign bus.err_underflow   = r_err_underflow;

endmodule
